// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
// Shares one single-port register file between two requesters, A and B.
// Each requester issues read/write commands over a valid/ready handshake.
// Commands are granted round-robin and sent to the register file one at a
// time. Exactly one response goes back to the requester that issued each
// accepted command.
//
// Ports
//   clk, reset               single rising-edge clock, synchronous active-high reset
//   req_{a,b}_valid/ready    command handshake (ready is combinational)
//   req_{a,b}_wr/addr/wdata  command contents (wr=1 write, wr=0 read)
//   rsp_{a,b}_valid          one-cycle response pulse
//   rsp_{a,b}_rdata/err      read data / read-without-valid error flag
//   rf_RdEN/WrEN/address/WrData  register file command outputs (registered)
//   rf_RdData/RdData_Valid   register file read return
//   busy                     high whenever the FSM is not idle
module reg_file_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_a_valid,
    output logic                  req_a_ready,
    input  logic                  req_a_wr,
    input  logic [ADDR_WIDTH-1:0] req_a_addr,
    input  logic [DATA_WIDTH-1:0] req_a_wdata,
    output logic                  rsp_a_valid,
    output logic [DATA_WIDTH-1:0] rsp_a_rdata,
    output logic                  rsp_a_err,

    input  logic                  req_b_valid,
    output logic                  req_b_ready,
    input  logic                  req_b_wr,
    input  logic [ADDR_WIDTH-1:0] req_b_addr,
    input  logic [DATA_WIDTH-1:0] req_b_wdata,
    output logic                  rsp_b_valid,
    output logic [DATA_WIDTH-1:0] rsp_b_rdata,
    output logic                  rsp_b_err,

    output logic                  rf_RdEN,
    output logic                  rf_WrEN,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_WrData,
    input  logic [DATA_WIDTH-1:0] rf_RdData,
    input  logic                  rf_RdData_Valid,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    state_t                state_q, state_d;
    grant_t                lastGrant_q, lastGrant_d;
    grant_t                cmdId_q, cmdId_d;
    logic                  cmdWr_q, cmdWr_d;

    logic                  rfRdEn_q, rfRdEn_d;
    logic                  rfWrEn_q, rfWrEn_d;
    logic [ADDR_WIDTH-1:0] rfAddress_q, rfAddress_d;
    logic [DATA_WIDTH-1:0] rfWrData_q, rfWrData_d;

    logic                  rspAValid_q, rspAValid_d;
    logic [DATA_WIDTH-1:0] rspARdata_q, rspARdata_d;
    logic                  rspAErr_q, rspAErr_d;
    logic                  rspBValid_q, rspBValid_d;
    logic [DATA_WIDTH-1:0] rspBRdata_q, rspBRdata_d;
    logic                  rspBErr_q, rspBErr_d;
    logic                  busy_q, busy_d;

    logic                  aWins, bWins;
    logic                  acceptA, acceptB;
    logic                  selWr;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic [DATA_WIDTH-1:0] rdResult;

    // On a tie the requester that was not granted last wins; a lone requester
    // always wins. Only the winner sees ready, and only while idle and out of reset.
    assign aWins = req_a_valid && (!req_b_valid || (lastGrant_q == GRANT_B));
    assign bWins = req_b_valid && (!req_a_valid || (lastGrant_q == GRANT_A));

    assign req_a_ready = (state_q == IDLE) && !reset && aWins;
    assign req_b_ready = (state_q == IDLE) && !reset && bWins;

    assign acceptA = req_a_ready;
    assign acceptB = req_b_ready;

    assign selWr    = acceptB ? req_b_wr    : req_a_wr;
    assign selAddr  = acceptB ? req_b_addr  : req_a_addr;
    assign selWdata = acceptB ? req_b_wdata : req_a_wdata;

    // A read without the valid flag reports an error and never leaks stale data.
    assign rdResult = rf_RdData_Valid ? rf_RdData : '0;

    // Next-state logic. The rf strobes are loaded on accept so that they sit
    // on the registered outputs for exactly the CMD cycle. The response for a
    // write is loaded in CMD and the response for a read in RD_WAIT, so both
    // land in the cycle the FSM returns to IDLE.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        cmdId_d     = cmdId_q;
        cmdWr_d     = cmdWr_q;
        rfRdEn_d    = 1'b0;
        rfWrEn_d    = 1'b0;
        rfAddress_d = rfAddress_q;
        rfWrData_d  = rfWrData_q;
        rspAValid_d = 1'b0;
        rspARdata_d = '0;
        rspAErr_d   = 1'b0;
        rspBValid_d = 1'b0;
        rspBRdata_d = '0;
        rspBErr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (acceptA || acceptB) begin
                    state_d     = CMD;
                    lastGrant_d = acceptB ? GRANT_B : GRANT_A;
                    cmdId_d     = acceptB ? GRANT_B : GRANT_A;
                    cmdWr_d     = selWr;
                    rfRdEn_d    = !selWr;
                    rfWrEn_d    = selWr;
                    rfAddress_d = selAddr;
                    rfWrData_d  = selWr ? selWdata : '0;
                end
            end
            CMD: begin
                if (cmdWr_q) begin
                    state_d = IDLE;
                    if (cmdId_q == GRANT_B) begin
                        rspBValid_d = 1'b1;
                    end else begin
                        rspAValid_d = 1'b1;
                    end
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                if (cmdId_q == GRANT_B) begin
                    rspBValid_d = 1'b1;
                    rspBRdata_d = rdResult;
                    rspBErr_d   = !rf_RdData_Valid;
                end else begin
                    rspAValid_d = 1'b1;
                    rspARdata_d = rdResult;
                    rspAErr_d   = !rf_RdData_Valid;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset aborts any command in flight, so no
    // response is ever produced for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_B;
            cmdId_q     <= GRANT_A;
            cmdWr_q     <= 1'b0;
            rfRdEn_q    <= 1'b0;
            rfWrEn_q    <= 1'b0;
            rfAddress_q <= '0;
            rfWrData_q  <= '0;
            rspAValid_q <= 1'b0;
            rspARdata_q <= '0;
            rspAErr_q   <= 1'b0;
            rspBValid_q <= 1'b0;
            rspBRdata_q <= '0;
            rspBErr_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            cmdId_q     <= cmdId_d;
            cmdWr_q     <= cmdWr_d;
            rfRdEn_q    <= rfRdEn_d;
            rfWrEn_q    <= rfWrEn_d;
            rfAddress_q <= rfAddress_d;
            rfWrData_q  <= rfWrData_d;
            rspAValid_q <= rspAValid_d;
            rspARdata_q <= rspARdata_d;
            rspAErr_q   <= rspAErr_d;
            rspBValid_q <= rspBValid_d;
            rspBRdata_q <= rspBRdata_d;
            rspBErr_q   <= rspBErr_d;
            busy_q      <= busy_d;
        end
    end

    assign rf_RdEN     = rfRdEn_q;
    assign rf_WrEN     = rfWrEn_q;
    assign rf_address  = rfAddress_q;
    assign rf_WrData   = rfWrData_q;
    assign rsp_a_valid = rspAValid_q;
    assign rsp_a_rdata = rspARdata_q;
    assign rsp_a_err   = rspAErr_q;
    assign rsp_b_valid = rspBValid_q;
    assign rsp_b_rdata = rspBRdata_q;
    assign rsp_b_err   = rspBErr_q;
    assign busy        = busy_q;

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-port arbiter that shares the single-port register file between two independent requesters (A and B). Accepts read/write requests over valid/ready handshakes, grants them round-robin, sequences the register file's RdEN/WrEN/address/WrData controls one command at a time, and returns exactly one response per accepted request to the originating requester. The arbiter sits directly in front of the register file. No other block drives the register file's command inputs.

## Interface
- DATA_WIDTH, 32, data width; must match the register file.
- ADDR_WIDTH, 4, register address width; must match the register file.

- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_a_valid  input  1  requester A has a command.
- req_a_ready  output  1  A's command accepted this cycle when high with req_a_valid.
- req_a_wr  input  1  1 = write, 0 = read.
- req_a_addr  input  ADDR_WIDTH  register address.
- req_a_wdata  input  DATA_WIDTH  write data.
- rsp_a_valid  output  1  one-cycle response pulse to A.
- rsp_a_rdata  output  DATA_WIDTH  read data; 0 for write responses.
- rsp_a_err  output  1  read returned without rf_RdData_Valid.
- req_b_* / rsp_b_*: identical set for requester B.
- rf_RdEN  output  1  register file read enable.
- rf_WrEN  output  1  register file write enable.
- rf_address  output  ADDR_WIDTH  register file address.
- rf_WrData  output  DATA_WIDTH  register file write data.
- rf_RdData  input  DATA_WIDTH  register file read data.
- rf_RdData_Valid  input  1  register file read-valid flag.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: ready may be asserted; on accept, go to CMD.
  - CMD: the registered command is driven onto rf_*. Go to IDLE for a write, or RD_WAIT for a read.
  - RD_WAIT: sample rf_RdData and rf_RdData_Valid, then go to IDLE.
- Arbitration happens only in IDLE.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - last_grant resets to B, so A wins the first tie.
  - last_grant updates only on accept.
- req_x_ready is combinational: high only in IDLE, only for the arbitration winner, and only while not in reset. The loser's ready stays low. Both readys are low outside IDLE.
- On accept, capture wr/addr/wdata and the grant id into command registers. Requester inputs are ignored afterwards.
- In CMD, exactly one of rf_RdEN/rf_WrEN is 1 for exactly one cycle. rf_address and rf_WrData come from the command register.
  - rf_WrData = 0 on reads.
  - The arbiter never asserts rf_RdEN and rf_WrEN together.
- The arbiter does not trust the rf_RdData_Valid level outside RD_WAIT. The flag may stay high across later cycles and is ignored there.
- Responses go only to the granted requester:
  - Write: rsp_valid=1, rdata=0, err=0.
  - Read: rdata = the rf_RdData sampled in RD_WAIT, err = !rf_RdData_Valid sampled in RD_WAIT. If err=1, rdata is forced to 0.
- A requester may hold req_valid across its own pending response. It is re-arbitrated in the next IDLE cycle.

## Timing
- Accept in cycle N. rf command in cycle N+1.
  - Write: rsp_valid pulses in N+2, and the FSM is back in IDLE in N+2, so the next accept can occur in N+2.
  - Read: RD_WAIT in N+2. rsp_valid with data in N+3, FSM in IDLE in N+3.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- With both requesters continuously valid, grants alternate strictly A, B, A, B. Maximum wait for either requester is one full command of the other.
- All outputs are registered except req_a_ready/req_b_ready.
- Reset values: state=IDLE, last_grant=B, rf_RdEN=rf_WrEN=0, rf_address=0, rf_WrData=0, rsp_*_valid=0, rsp_*_rdata=0, rsp_*_err=0, busy=0. Both readys are 0 while reset=1.
- Reset mid-operation (in CMD or RD_WAIT) aborts the command. The next cycle has rf_* deasserted and no response pulse is ever emitted for the aborted request. The requester must reissue.
- rsp pulses last exactly one cycle. rsp_a_valid and rsp_b_valid are never high together.

## Test plan
- A writes 0xDEADBEEF to address 5, then reads address 5 -> rf_WrEN=1 with address 5 one cycle after accept. Write rsp in N+2. Read rsp_a_rdata=0xDEADBEEF, err=0, exactly 3 cycles after the read accept.
- A and B both valid from reset, each issuing reads, for 4 transactions -> grant order A, B, A, B. Each readys only on its own turn. Responses route to the matching requester only.
- Back-to-back writes from B to addresses 0..15 while A is idle -> one accept every 2 cycles. rf_address increments 0..15. busy toggles 1,0 pattern.
- Read where the bench holds rf_RdData_Valid=0 in RD_WAIT -> rsp_err=1, rsp_rdata=0. The next transaction proceeds normally.
- Write issued immediately after a read to the same address, with rf_RdData_Valid left high by the bench -> write rsp has rdata=0, err=0. No spurious second read response.
- Assert reset in RD_WAIT of a read from A -> no rsp_a_valid ever for that read. All outputs hold their reset values the cycle after reset. A's first tie after reset still wins.
